rv32i_dmem_responder: RTL and testbench
=======================================

# rv32i_dmem_responder

Data-memory responder for the RV32I core's load/store path. It accepts one request at a time from the memory stage: a byte address, lane-aligned store data, a 4-bit write mask and a store/load flag. After a configurable number of wait states it performs the access on an internal word-organised RAM and returns the full 32-bit word with a one-cycle acknowledge. Byte/halfword extraction and sign extension remain in the memory stage; this block only serves whole words with per-byte write enables.

## Interface
- DEPTH, 1024: RAM size in 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 1: extra cycles between request acceptance and ack; 0..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
- wdata  input  32  store data, already lane-aligned.
- wmask  input  4  byte write enables {b3,b2,b1,b0}; ignored for loads.
- rdata  output  32  registered read word; valid while ack=1.
- ack  output  1  one-cycle completion pulse.
- err  output  1  out-of-range fault; valid only with ack.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE, req=1:
  - Latch we, addr, wdata and wmask into request registers.
  - Load cnt ← WAIT_CYCLES.
  - If WAIT_CYCLES=0: perform the access at this edge and go to RESP. Otherwise go to WAIT.
- IDLE, req=0: stay in IDLE.
- WAIT: cnt decrements each cycle. At the edge where cnt=1, perform the access and go to RESP.
- RESP: ack=1 for exactly this cycle, then go to IDLE unconditionally.
- Performing the access uses the latched request only. Changes on the input ports after acceptance have no effect.
- Range check: range error when addr[31:log2(DEPTH)+2] ≠ 0.
  - err ← 1, rdata ← 0, no RAM write.
- Load, in range: rdata ← mem[idx], err ← 0.
- Store, in range:
  - For each lane i with wmask[i]=1: mem[idx][8i+7:8i] ← wdata[8i+7:8i]. Other lanes are unchanged.
  - rdata ← 0, err ← 0.
  - wmask=0000 writes nothing and still completes with ack.
- req while busy=1 is ignored, not queued. The initiator re-asserts req after ack.
- RAM contents are not reset and are undefined until written. The bench pre-loads them through hierarchical access or stores.

## Timing
- Reset values: rdata=0, ack=0, err=0, busy=0, state=IDLE, cnt=0.
- Latency: req high in cycle 0 (sampled at the end of cycle 0) → ack high in cycle 1+WAIT_CYCLES.
- busy is high in cycles 1 .. 1+WAIT_CYCLES inclusive and falls the cycle after ack.
- Throughput: at most one request per WAIT_CYCLES+2 cycles. The earliest next req is the cycle after ack.
- RAM write commits at the same edge that raises ack. A load accepted after that ack returns the new data.
- rdata and err change only at the edge entering RESP and hold until the next access edge. Only the ack cycle is guaranteed valid.
- Reset asserted mid-operation:
  - All outputs and the FSM return to reset values immediately.
  - A store whose commit edge has not occurred is dropped, so RAM is unchanged.
  - No ack is issued for the aborted request.
- req held high continuously: a new request is accepted on each return to IDLE, i.e. every WAIT_CYCLES+2 cycles.

## Test plan
- Load latency: WAIT_CYCLES=2, mem[5]=32'hDEADBEEF, req load addr=0x14 in cycle 0 → ack only in cycle 3 with rdata=32'hDEADBEEF, err=0; busy high in cycles 1–3.
- Masked store: mem[2]=32'h11223344, store addr=0x08 wdata=32'h00AA0000 wmask=0100 → subsequent load returns 32'h11AA3344; wmask=0000 store leaves it unchanged but still acks.
- Out of range: DEPTH=1024, load addr=0x0000_1000 → ack with err=1, rdata=0; store to the same address changes no RAM word.
- Ignored request: assert req again in the WAIT and RESP cycles → exactly one ack; next req in the cycle after ack is accepted normally.
- Zero wait / back-to-back: WAIT_CYCLES=0, req held high with a store to 0x0 then a load from 0x0 → acks in cycles 1 and 3, and the load returns the stored word.
- Reset mid-op: WAIT_CYCLES=3, store to 0x10, deassert rst_n in cycle 2 → ack/busy/rdata/err=0 at once, no ack afterward, mem[4] unchanged.

Source files
------------

// File: rtl/rv32i_dmem_responder.sv
// Word-wide data RAM responder: one request at a time, ack arrives WAIT_CYCLES+1 cycles after acceptance.
// Requests arriving while busy are dropped; the initiator re-asserts req after ack.
module rv32i_dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int   AW        = $clog2(DEPTH);
    localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;

    logic [31:0] mem [DEPTH];

    logic          a_we;
    logic [31:0]   a_addr;
    logic [31:0]   a_wdata;
    logic [3:0]    a_wmask;
    logic [AW-1:0] a_idx;
    logic          a_oob;
    logic          go;
    logic [31:0]   rd_val;

    // With zero wait states the access happens at the acceptance edge, so the
    // request is taken straight from the ports; otherwise from the latched copy.
    always_comb begin
        a_we    = (state == IDLE) ? we    : r_we;
        a_addr  = (state == IDLE) ? addr  : r_addr;
        a_wdata = (state == IDLE) ? wdata : r_wdata;
        a_wmask = (state == IDLE) ? wmask : r_wmask;
        a_idx   = a_addr[AW+1:2];
        a_oob   = |a_addr[31:AW+2];
        go      = rst_n && (((state == IDLE) && req && ZERO_WAIT) ||
                            ((state == WAIT) && (cnt == 4'd1)));
        rd_val  = (a_oob || a_we) ? 32'h0 : mem[a_idx];
    end

    always_ff @(posedge clk) begin
        if (go && a_we && !a_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (a_wmask[i]) begin
                    mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wmask <= 4'h0;
            rdata   <= 32'h0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_wmask <= wmask;
                        cnt     <= 4'(WAIT_CYCLES);
                        busy    <= 1'b1;
                        if (ZERO_WAIT) begin
                            state <= RESP;
                            ack   <= 1'b1;
                            rdata <= rd_val;
                            err   <= a_oob;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        ack   <= 1'b1;
                        rdata <= rd_val;
                        err   <= a_oob;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Three responders (2, 0 and 3 wait states) checked against a cycle-count/array model.
module tb_rv32i_dmem_responder;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [NI];
    logic        req   [NI];
    logic        we    [NI];
    logic [31:0] addr  [NI];
    logic [31:0] wdata [NI];
    logic [3:0]  wmask [NI];
    logic [31:0] rdata [NI];
    logic        ack   [NI];
    logic        err   [NI];
    logic        busy  [NI];

    rv32i_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .wmask(wmask[0]), .rdata(rdata[0]), .ack(ack[0]),
        .err(err[0]), .busy(busy[0]));
    rv32i_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .wmask(wmask[1]), .rdata(rdata[1]), .ack(ack[1]),
        .err(err[1]), .busy(busy[1]));
    rv32i_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .wdata(wdata[2]), .wmask(wmask[2]), .rdata(rdata[2]), .ack(ack[2]),
        .err(err[2]), .busy(busy[2]));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: a request accepted at the end of cycle c acks in cycle c+1+W.
    bit          pend  [NI];
    int          ack_c [NI];
    bit          p_we  [NI];
    logic [31:0] p_addr[NI];
    logic [31:0] p_wdat[NI];
    logic [3:0]  p_msk [NI];
    logic [31:0] e_rd  [NI];
    bit          e_err [NI];
    bit          e_rk  [NI];
    logic [31:0] mm    [NI][1024];
    logic [3:0]  kb    [NI][1024];

    function automatic int wc(int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic logic [31:0] get_mem(int k, int i);
        case (k)
            0:       return dut0.mem[i];
            1:       return dut1.mem[i];
            default: return dut2.mem[i];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_access(input int k);
        int  idx;
        bit  oob;
        idx = int'(p_addr[k][11:2]);
        oob = (p_addr[k][31:12] != 20'h0);
        e_err[k] = oob;
        e_rd[k]  = 32'h0;
        e_rk[k]  = 1'b1;
        if (!oob && p_we[k]) begin
            for (int b = 0; b < 4; b++) begin
                if (p_msk[k][b]) begin
                    mm[k][idx][8*b +: 8] = p_wdat[k][8*b +: 8];
                    kb[k][idx][b] = 1'b1;
                end
            end
        end else if (!oob) begin
            e_rd[k] = mm[k][idx];
            e_rk[k] = (kb[k][idx] == 4'hf);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) begin
                if (!rst_n[k]) begin
                    pend[k]  = 1'b0;
                    e_rd[k]  = 32'h0;
                    e_err[k] = 1'b0;
                    e_rk[k]  = 1'b1;
                end else begin
                    if (pend[k] && cyc > ack_c[k]) pend[k] = 1'b0;
                    if (!pend[k] && req[k]) begin
                        pend[k]   = 1'b1;
                        ack_c[k]  = cyc + 1 + wc(k);
                        p_we[k]   = we[k];
                        p_addr[k] = addr[k];
                        p_wdat[k] = wdata[k];
                        p_msk[k]  = wmask[k];
                    end
                    if (pend[k] && cyc == ack_c[k] - 1) model_access(k);
                end
            end
            cyc = cyc + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (!rst_n[k]) begin
                    chk($sformatf("rst_ack%0d", k), 32'(ack[k]), 32'h0);
                    chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'h0);
                    chk($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
                    chk($sformatf("rst_err%0d", k), 32'(err[k]), 32'h0);
                end else begin
                    bit xa, xb;
                    xa = pend[k] && (cyc == ack_c[k]);
                    xb = pend[k] && (cyc <= ack_c[k]);
                    chk($sformatf("ack%0d", k), 32'(ack[k]), 32'(xa));
                    chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(xb));
                    if (xa) begin
                        chk($sformatf("err%0d", k), 32'(err[k]), 32'(e_err[k]));
                        if (e_rk[k]) chk($sformatf("rdata%0d", k), rdata[k], e_rd[k]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        req[k] = r; we[k] = w; addr[k] = a; wdata[k] = d; wmask[k] = m;
    endtask

    task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rd, output logic er);
        drive(k, 1'b1, w, a, d, m);
        step();
        req[k] = 1'b0;
        for (int n = 0; n < 40 && !ack[k]; n++) step();
        if (!ack[k]) chk("ack_timeout", 32'h0, 32'h1);
        rd = rdata[k];
        er = err[k];
        step();
    endtask

    logic [31:0] rd;
    logic        er;
    bit          seen;

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b1;
            drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            pend[k] = 1'b0; e_rd[k] = 32'h0; e_err[k] = 1'b0; e_rk[k] = 1'b1;
            for (int i = 0; i < 1024; i++) kb[k][i] = 4'h0;
        end
        #1;
        for (int k = 0; k < NI; k++) rst_n[k] = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("reset_ack", 32'(ack[k]), 32'h0);
            chk("reset_busy", 32'(busy[k]), 32'h0);
            chk("reset_rdata", rdata[k], 32'h0);
            chk("reset_err", 32'(err[k]), 32'h0);
        end
        step(); step();
        for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
        step();

        // Load latency with 2 wait states, plus requests held through WAIT/RESP.
        txn(0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hf, rd, er);
        drive(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        step();
        chk("lat_c1_busy", 32'(busy[0]), 32'h1);
        chk("lat_c1_ack", 32'(ack[0]), 32'h0);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h0, 4'hf);
        step();
        chk("lat_c2_busy", 32'(busy[0]), 32'h1);
        chk("lat_c2_ack", 32'(ack[0]), 32'h0);
        step();
        chk("lat_c3_ack", 32'(ack[0]), 32'h1);
        chk("lat_c3_rdata", rdata[0], 32'hDEADBEEF);
        chk("lat_c3_err", 32'(err[0]), 32'h0);
        chk("lat_c3_busy", 32'(busy[0]), 32'h1);
        drive(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        step();
        chk("lat_c4_ack", 32'(ack[0]), 32'h0);
        chk("lat_c4_busy", 32'(busy[0]), 32'h0);
        step();
        chk("next_c5_busy", 32'(busy[0]), 32'h1);
        req[0] = 1'b0;
        step();
        chk("next_c6_ack", 32'(ack[0]), 32'h0);
        step();
        chk("next_c7_ack", 32'(ack[0]), 32'h1);
        chk("next_c7_rdata", rdata[0], 32'hDEADBEEF);
        step();

        // Masked store and empty-mask store.
        txn(0, 1'b1, 32'h08, 32'h11223344, 4'hf, rd, er);
        txn(0, 1'b1, 32'h08, 32'h00AA0000, 4'b0100, rd, er);
        txn(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er);
        chk("mask_load", rd, 32'h11AA3344);
        txn(0, 1'b1, 32'h0A, 32'hFFFFFFFF, 4'h0, rd, er);
        txn(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er);
        chk("nomask_load", rd, 32'h11AA3344);

        // Out of range: 0x1000 would alias word 0 if the range check were missing.
        txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hf, rd, er);
        txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er);
        chk("oob_load_err", 32'(er), 32'h1);
        chk("oob_load_rdata", rd, 32'h0);
        txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hf, rd, er);
        chk("oob_store_err", 32'(er), 32'h1);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er);
        chk("oob_word0", rd, 32'hCAFEF00D);
        chk("oob_word0_err", 32'(er), 32'h0);

        // Zero wait states, req held: store then load at cycles 0 and 2.
        drive(1, 1'b1, 1'b1, 32'h0, 32'h12345678, 4'hf);
        step();
        chk("zw_c1_ack", 32'(ack[1]), 32'h1);
        chk("zw_c1_busy", 32'(busy[1]), 32'h1);
        chk("zw_c1_rdata", rdata[1], 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        chk("zw_c2_ack", 32'(ack[1]), 32'h0);
        chk("zw_c2_busy", 32'(busy[1]), 32'h0);
        step();
        chk("zw_c3_ack", 32'(ack[1]), 32'h1);
        chk("zw_c3_rdata", rdata[1], 32'h12345678);
        req[1] = 1'b0;
        step();
        chk("zw_c4_ack", 32'(ack[1]), 32'h0);
        step();

        // Reset mid-operation drops the pending store.
        txn(2, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hf, rd, er);
        txn(2, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        chk("rmo_pre_load", rd, 32'hA5A5A5A5);
        drive(2, 1'b1, 1'b1, 32'h10, 32'h0, 4'hf);
        step();
        req[2] = 1'b0;
        step();
        #1 rst_n[2] = 1'b0;
        #1;
        chk("rmo_ack", 32'(ack[2]), 32'h0);
        chk("rmo_busy", 32'(busy[2]), 32'h0);
        chk("rmo_rdata", rdata[2], 32'h0);
        chk("rmo_err", 32'(err[2]), 32'h0);
        step(); step();
        rst_n[2] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step();
            seen = seen | ack[2];
        end
        chk("rmo_no_ack", 32'(seen), 32'h0);
        chk("rmo_mem4", get_mem(2, 4), 32'hA5A5A5A5);
        txn(2, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        chk("rmo_load", rd, 32'hA5A5A5A5);

        // Fill words 0..15 on every instance, then random traffic.
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 16; i++)
                txn(k, 1'b1, 32'(i * 4), $urandom, 4'hf, rd, er);
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < NI; k++) begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
                else a = a & 32'h3F;
                drive(k, ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), a, $urandom,
                      4'($urandom_range(0, 15)));
                rst_n[k] = ($urandom_range(0, 149) != 0);
            end
            step();
        end
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b1;
            req[k]   = 1'b0;
        end
        for (int n = 0; n < 8; n++) step();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 16; i++)
                if (kb[k][i] == 4'hf) chk($sformatf("mem%0d_%0d", k, i), get_mem(k, i), mm[k][i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
